// File: rtl/wb_arbiter_pkg.sv
// Shared register-file writeback types for the core.
package rv_core_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } fwd_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU/LSU result inputs, register-file write port, forwarding lookups.
interface wb_arbiter_if #(parameter int unsigned DEPTH = 4);
  import rv_core_pkg::*;

  logic                    alu_valid;
  logic [REG_ADDR_W-1:0]   alu_rd;
  logic [XLEN-1:0]         alu_data;
  logic                    lsu_valid;
  logic                    lsu_ready;
  logic [REG_ADDR_W-1:0]   lsu_rd;
  logic [XLEN-1:0]         lsu_data;
  logic                    rf_write_enable;
  logic [REG_ADDR_W-1:0]   rf_write_reg;
  logic [XLEN-1:0]         rf_write_data;
  logic [REG_ADDR_W-1:0]   fwd_rs1;
  logic [REG_ADDR_W-1:0]   fwd_rs2;
  logic                    fwd_hit1;
  logic                    fwd_hit2;
  logic [XLEN-1:0]         fwd_data1;
  logic [XLEN-1:0]         fwd_data2;
  logic [$clog2(DEPTH):0]  lsu_pending;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1, fwd_rs2,
    input  lsu_ready, rf_write_enable, rf_write_reg, rf_write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, lsu_pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, fwd_rs1, fwd_rs2,
    output lsu_ready, rf_write_enable, rf_write_reg, rf_write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, lsu_pending
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// LSU writeback FIFO; entries are exposed in age order (index 0 = oldest) for forwarding.
module wb_fifo
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  wb_req_t                din_i,
  output wb_req_t                dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output wb_req_t [DEPTH-1:0]    entries_o,
  output logic [DEPTH-1:0]       valid_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[head_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q + PW'(pop_ok);
    tail_d  = tail_q + PW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= din_i;
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries_o[k] = mem_q[head_q + PW'(k)];
      valid_o[k]   = (CW'(k) < count_q);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU has strict priority, LSU results queue in a FIFO.
module wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  wb_req_t               fifo_head;
  wb_req_t [DEPTH-1:0]   fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  alu_win, push, pop;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] reg_q, reg_d;
  logic [XLEN-1:0]       data_q, data_d;
  fwd_t                  fwd1, fwd2;

  // An ALU write to x0 is not a real write and must not steal the port from the FIFO.
  assign alu_win       = bus.alu_valid && (bus.alu_rd != '0);
  assign pop           = !alu_win && !fifo_empty;
  assign bus.lsu_ready = rst_n && !fifo_full;
  assign push          = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     ('{rd: bus.lsu_rd, data: bus.lsu_data}),
    .dout_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .entries_o (fifo_entries),
    .valid_o   (fifo_valid)
  );

  always_comb begin
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    if (alu_win) begin
      we_d   = 1'b1;
      reg_d  = bus.alu_rd;
      data_d = bus.alu_data;
    end else if (pop) begin
      we_d   = 1'b1;
      reg_d  = fifo_head.rd;
      data_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  // Registered write is the oldest pending value; FIFO entries scanned oldest to youngest so the youngest match wins.
  function automatic fwd_t lookup(input logic [REG_ADDR_W-1:0] rs);
    fwd_t r;
    r = '0;
    if (rs != '0) begin
      if (we_q && (reg_q == rs)) begin
        r.hit  = 1'b1;
        r.data = data_q;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (fifo_valid[k] && (fifo_entries[k].rd == rs)) begin
          r.hit  = 1'b1;
          r.data = fifo_entries[k].data;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd1 = lookup(bus.fwd_rs1);
    fwd2 = lookup(bus.fwd_rs2);
  end

  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_reg    = reg_q;
  assign bus.rf_write_data   = data_q;
  assign bus.fwd_hit1        = fwd1.hit;
  assign bus.fwd_data1       = fwd1.data;
  assign bus.fwd_hit2        = fwd2.hit;
  assign bus.fwd_data2       = fwd2.data;
  assign bus.lsu_pending     = fifo_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
  wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model on the current inputs, then let the DUT see the same edge.
  task automatic cycle();
    ent_t e;
    logic ready;
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0;
    end else begin
      ready = (mq.size() < DEPTH);
      if (bus.alu_valid && bus.alu_rd != 5'd0) begin
        m_we = 1'b1; m_reg = bus.alu_rd; m_data = bus.alu_data;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_reg = e.rd; m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (bus.lsu_valid && ready && bus.lsu_rd != 5'd0) begin
        e.rd = bus.lsu_rd; e.data = bus.lsu_data;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void mfwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    if (rs == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].rd == rs) begin
        hit = 1'b1; d = mq[i].data;
        return;
      end
    end
    if (m_we && m_reg == rs) begin
      hit = 1'b1; d = m_data;
    end
  endfunction

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.fwd_rs1 = '0; bus.fwd_rs2 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    vectors++;
    if (bus.lsu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %0b want 0", bus.lsu_ready); end
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %0b want 0", bus.rf_write_enable); end
    vectors++;
    if (bus.rf_write_reg !== 5'd0 || bus.rf_write_data !== 32'd0) begin
      miscompares++; $display("FAIL reset_reg_data: got %0d/%h want 0/0", bus.rf_write_reg, bus.rf_write_data);
    end
    vectors++;
    if (bus.lsu_pending !== 3'd0) begin miscompares++; $display("FAIL reset_pending: got %0d want 0", bus.lsu_pending); end
    vectors++;
    if (bus.lsu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %0b want 1", bus.lsu_ready); end
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    cycle();
    idle_inputs();
    #1;
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd5 || bus.rf_write_data !== 32'h1234) begin
      miscompares++;
      $display("FAIL alu_write: got we=%0b rd=%0d data=%h want 1/5/00001234",
               bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data);
    end
    cycle();
    vectors++;
    if (bus.rf_write_enable !== 1'b0 || bus.rf_write_reg !== 5'd5) begin
      miscompares++; $display("FAIL alu_idle: got we=%0b rd=%0d want 0/5", bus.rf_write_enable, bus.rf_write_reg);
    end
  endtask

  task automatic test_lsu_only();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (bus.lsu_ready !== 1'b1) begin miscompares++; $display("FAIL lsu_ready: got %0b want 1", bus.lsu_ready); end
    cycle();
    idle_inputs();
    #1;
    vectors++;
    if (bus.lsu_pending !== 3'd1 || bus.rf_write_enable !== 1'b0) begin
      miscompares++; $display("FAIL lsu_queued: got pend=%0d we=%0b want 1/0", bus.lsu_pending, bus.rf_write_enable);
    end
    cycle();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd7 || bus.rf_write_data !== 32'hDEADBEEF
        || bus.lsu_pending !== 3'd0) begin
      miscompares++;
      $display("FAIL lsu_write: got we=%0b rd=%0d data=%h pend=%0d want 1/7/deadbeef/0",
               bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data, bus.lsu_pending);
    end
  endtask

  task automatic test_backpressure();
    int   idx;
    logic acc;
    logic [4:0] got[$];
    logic [31:0] gotd[$];
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(1 + c); bus.alu_data = 32'(c);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(10 + idx); bus.lsu_data = 32'h100 + 32'(10 + idx);
      #1;
      vectors++;
      if (bus.lsu_ready !== (idx < 4)) begin
        miscompares++; $display("FAIL bp_ready c%0d: got %0b want %0b", c, bus.lsu_ready, idx < 4);
      end
      acc = bus.lsu_ready;
      cycle();
      if (acc) idx++;
    end
    #1;
    vectors++;
    if (bus.lsu_pending !== 3'd4 || bus.lsu_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_full: got pend=%0d ready=%0b want 4/0", bus.lsu_pending, bus.lsu_ready);
    end
    bus.alu_valid = 1'b0;
    for (int c = 0; c < 12 && got.size() < 5; c++) begin
      #1;
      acc = bus.lsu_valid && bus.lsu_ready;
      cycle();
      if (acc) bus.lsu_valid = 1'b0;
      if (bus.rf_write_enable === 1'b1) begin
        got.push_back(bus.rf_write_reg);
        gotd.push_back(bus.rf_write_data);
      end
    end
    vectors++;
    if (got.size() != 5) begin miscompares++; $display("FAIL bp_drain_count: got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      vectors++;
      if (got[i] !== 5'(10 + i) || gotd[i] !== 32'h100 + 32'(10 + i)) begin
        miscompares++; $display("FAIL bp_order[%0d]: got %0d/%h want %0d/%h", i, got[i], gotd[i], 10 + i, 32'h100 + 32'(10 + i));
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    cycle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD;
    bus.lsu_valid = 1'b0;
    cycle();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd3 || bus.rf_write_data !== 32'h33) begin
      miscompares++;
      $display("FAIL x0_alu_pop: got we=%0b rd=%0d data=%h want 1/3/00000033",
               bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data);
    end
    idle_inputs();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h77;
    #1;
    vectors++;
    if (bus.lsu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_lsu_ready: got %0b want 1", bus.lsu_ready); end
    cycle();
    idle_inputs();
    #1;
    vectors++;
    if (bus.lsu_pending !== 3'd0 || bus.rf_write_enable !== 1'b0) begin
      miscompares++; $display("FAIL x0_lsu_drop: got pend=%0d we=%0b want 0/0", bus.lsu_pending, bus.rf_write_enable);
    end
    cycle();
    vectors++;
    if (bus.rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL x0_lsu_nowrite: got %0b want 0", bus.rf_write_enable); end
  endtask

  task automatic test_forward();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h1;
    cycle();
    bus.alu_rd = 5'd21; bus.alu_data = 32'hA1;
    bus.lsu_data = 32'h2;
    cycle();
    bus.lsu_valid = 1'b0;
    bus.fwd_rs1 = 5'd9; bus.fwd_rs2 = 5'd0;
    #1;
    vectors++;
    if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 32'h2) begin
      miscompares++; $display("FAIL fwd_youngest: got %0b/%h want 1/00000002", bus.fwd_hit1, bus.fwd_data1);
    end
    vectors++;
    if (bus.fwd_hit2 !== 1'b0 || bus.fwd_data2 !== 32'h0) begin
      miscompares++; $display("FAIL fwd_x0: got %0b/%h want 0/00000000", bus.fwd_hit2, bus.fwd_data2);
    end
    bus.fwd_rs2 = 5'd21;
    #1;
    vectors++;
    if (bus.fwd_hit2 !== 1'b1 || bus.fwd_data2 !== 32'hA1) begin
      miscompares++; $display("FAIL fwd_regout: got %0b/%h want 1/000000a1", bus.fwd_hit2, bus.fwd_data2);
    end
    idle_inputs();
    cycle(); cycle(); cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = 32'(i);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(3 + i); bus.lsu_data = 32'h500 + 32'(i);
      cycle();
    end
    vectors++;
    if (bus.lsu_pending !== 3'd3) begin miscompares++; $display("FAIL rmid_fill: got %0d want 3", bus.lsu_pending); end
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.rf_write_enable !== 1'b0 || bus.lsu_pending !== 3'd0) begin
      miscompares++; $display("FAIL rmid_clear: got we=%0b pend=%0d want 0/0", bus.rf_write_enable, bus.lsu_pending);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      vectors++;
      if (bus.rf_write_enable !== 1'b0) begin
        miscompares++; $display("FAIL rmid_stale c%0d: got we=%0b rd=%0d want 0", i, bus.rf_write_enable, bus.rf_write_reg);
      end
    end
  endtask

  task automatic test_random();
    logic        stalled, eh;
    logic [31:0] ed;
    stalled = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.alu_valid = ($urandom_range(0, 9) < 4);
      bus.alu_rd    = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      if (!stalled) begin
        bus.lsu_valid = ($urandom_range(0, 9) < 6);
        bus.lsu_rd    = 5'($urandom_range(0, 7));
        bus.lsu_data  = $urandom;
      end
      bus.fwd_rs1 = 5'($urandom_range(0, 7));
      bus.fwd_rs2 = 5'($urandom_range(0, 7));
      #1;
      vectors++;
      if (bus.lsu_ready !== (rst_n && mq.size() < DEPTH)) begin
        miscompares++; $display("FAIL rnd_ready c%0d: got %0b want %0b", c, bus.lsu_ready, rst_n && mq.size() < DEPTH);
      end
      vectors++;
      if (bus.lsu_pending !== 3'(mq.size())) begin
        miscompares++; $display("FAIL rnd_pending c%0d: got %0d want %0d", c, bus.lsu_pending, mq.size());
      end
      vectors++;
      if (bus.rf_write_enable !== m_we || bus.rf_write_reg !== m_reg || bus.rf_write_data !== m_data) begin
        miscompares++;
        $display("FAIL rnd_write c%0d: got %0b/%0d/%h want %0b/%0d/%h", c,
                 bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data, m_we, m_reg, m_data);
      end
      mfwd(bus.fwd_rs1, eh, ed);
      vectors++;
      if (bus.fwd_hit1 !== eh || bus.fwd_data1 !== ed) begin
        miscompares++; $display("FAIL rnd_fwd1 c%0d rs=%0d: got %0b/%h want %0b/%h", c, bus.fwd_rs1, bus.fwd_hit1, bus.fwd_data1, eh, ed);
      end
      mfwd(bus.fwd_rs2, eh, ed);
      vectors++;
      if (bus.fwd_hit2 !== eh || bus.fwd_data2 !== ed) begin
        miscompares++; $display("FAIL rnd_fwd2 c%0d rs=%0d: got %0b/%h want %0b/%h", c, bus.fwd_rs2, bus.fwd_hit2, bus.fwd_data2, eh, ed);
      end
      stalled = bus.lsu_valid && !(rst_n && mq.size() < DEPTH);
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mq.delete();
    m_we = 1'b0; m_reg = '0; m_data = '0;
    test_reset();
    test_alu_only();
    test_lsu_only();
    test_backpressure();
    test_x0();
    test_forward();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side initiator for the 32x32 register file. It merges two writeback sources, the single-cycle ALU result and the variable-latency load/store unit (LSU) result, onto the file's single write port (write_enable / write_reg / write_data).
- LSU results are buffered in a small FIFO so the ALU never stalls.
- Pending (buffered or registered, not yet written) values are exposed through two forwarding lookup ports for the decode stage.

Parameters:
- XLEN, 32, data width
- DEPTH, 4, LSU writeback FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept LSU result
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  LSU result
- rf_write_enable  out  1  to register file write_enable
- rf_write_reg  out  5  to register file write_reg
- rf_write_data  out  XLEN  to register file write_data
- fwd_rs1, fwd_rs2  in  5  source register lookups
- fwd_hit1, fwd_hit2  out  1  pending value exists for rsN
- fwd_data1, fwd_data2  out  XLEN  pending value for rsN
- lsu_pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-low on rst_n. On reset: rf_write_enable=0, rf_write_reg=0, rf_write_data=0, FIFO emptied (pointers and count = 0), lsu_pending=0, lsu_ready=0 during the reset cycle and 1 in the first cycle after.
- Reset mid-operation discards all buffered LSU entries and any registered write. No partial write is issued.
- rf_write_* are registered outputs.
- Arbitration at each posedge, evaluated in this order:
  1. If alu_valid and alu_rd!=0, register the ALU {rd,data} onto rf_write_*.
  2. Otherwise, if the FIFO is non-empty, pop the head and register it.
  3. Otherwise rf_write_enable=0. rf_write_reg and rf_write_data hold their last values.
- ALU has strict priority. Sustained ALU traffic may starve the FIFO indefinitely; this is accepted behaviour.
- Latency:
  - ALU input in cycle N produces rf_write_enable=1 in cycle N+1.
  - LSU handshake in cycle N places the entry in the FIFO at N+1. With no competing ALU write, rf_write_enable=1 in N+2.
- Handshake:
  - lsu_ready = !full, derived from registered count only. A full FIFO does not accept in the same cycle it pops.
  - Transfer occurs when lsu_valid && lsu_ready.
  - lsu_data and lsu_rd must be held stable while lsu_valid && !lsu_ready.
- rd==0:
  - An ALU result to x0 produces no write and does not block a FIFO pop that cycle.
  - An LSU result to x0 completes the handshake but is not pushed.
- Simultaneous push and pop: count unchanged, pointers both advance modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.
- Ordering is FIFO within the LSU source only. WAW ordering between ALU and LSU is guaranteed upstream: the hazard unit never issues an ALU op to an rd with a pending LSU entry.
- Forwarding is combinational from current state and does not include this cycle's alu/lsu inputs:
  - rsN==0: hit=0, data=0.
  - Otherwise search valid FIFO entries from youngest (tail-1) to oldest; the first match wins.
  - If there is no FIFO match and rf_write_enable && rf_write_reg==rsN, forward rf_write_data.
  - Otherwise hit=0, data=0.

Decomposition:
- Package rv_core_pkg:
  - XLEN=32, REG_ADDR_W=5
  - typedef wb_req_t packed {logic [4:0] rd; logic [XLEN-1:0] data;}
- Sub-module wb_fifo (parameter DEPTH):
  - Storage array, pointers and count.
  - push/pop/full/empty/count.
  - Flat entry and valid vectors exposed for the forwarding search.
- Top-level wb_arbiter holds the arbiter, output register and forwarding priority logic.

Test Plan:
- Reset then ALU only: alu_valid=1, rd=5, data=0x1234 in cycle N -> rf_write_enable=1, rf_write_reg=5, rf_write_data=0x1234 in N+1. With no other traffic, rf_write_enable=0 in N+2.
- LSU only: rd=7, data=0xDEADBEEF accepted in cycle N -> lsu_pending=1 at N+1; write of x7=0xDEADBEEF visible in N+2; lsu_pending=0 after.
- Fill/backpressure: ALU valid every cycle (rd=1..), 5 LSU offers back-to-back (rd=10..14) -> lsu_ready drops after 4 accepts, lsu_pending=4, 5th held. Drop ALU -> FIFO drains rd 10,11,12,13 in order, 5th accepted once count<4, then written as rd 14. Pointer wrap covered.
- x0 handling: ALU rd=0 with FIFO holding rd=3 -> x3 written the next cycle. LSU rd=0 handshake -> lsu_pending unchanged, no write.
- Forwarding: FIFO holds rd=9=0x1 (older) then rd=9=0x2 (younger), fwd_rs1=9 -> hit1=1, data1=0x2. fwd_rs2=0 -> hit2=0, data2=0.
- Reset mid-operation: FIFO holding 3 entries, rst_n low one cycle -> rf_write_enable=0, lsu_pending=0, no stale entry written afterwards.
